radix_digit_extractor: RTL and testbench

//  Converts an unsigned binary value into NDIG digits of a runtime-selectable radix.

---
 rtl/radix_digit_extractor_if.sv | 21 ++
 rtl/radix_digit_extractor.sv | 159 +++++++++++++++
 tb/tb_radix_digit_extractor.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/radix_digit_extractor_if.sv
// Start/busy/done handshake and result bus for the radix digit extractor.
interface radix_digit_extractor_if #(
    parameter int WIDTH = 32,
    parameter int NDIG  = 6,
    parameter int DW    = 4
);
    logic              start;
    logic [WIDTH-1:0]  value;
    logic [DW:0]       radix;
    logic              busy;
    logic              done;
    logic              err;
    logic              overflow;
    logic [NDIG*DW-1:0] digits;
    logic [NDIG*7-1:0]  seg;

    modport master (output start, value, radix,
                    input  busy, done, err, overflow, digits, seg);
    modport slave  (input  start, value, radix,
                    output busy, done, err, overflow, digits, seg);
endinterface

// File: rtl/radix_digit_extractor.sv
// Unsigned binary to NDIG radix-N digits using one shared iterative restoring
// divider, with active-low seven-segment decode and optional leading-zero blanking.
module radix_digit_extractor #(
    parameter int WIDTH = 32,
    parameter int NDIG  = 6,
    parameter int DW    = 4,
    parameter int LZB   = 0
) (
    input  logic clk,
    input  logic rst,
    radix_digit_extractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int KW = $clog2(NDIG + 1);
    localparam logic [DW:0] RADIX_MAX = (DW+1)'(1) << DW;

    typedef enum logic [1:0] {IDLE, DIV, NEXT, DONE} stateT;

    stateT                  state;
    logic [WIDTH-1:0]       dvd;
    logic [DW:0]            rem;
    logic [DW:0]            radixQ;
    logic [CW-1:0]          bitCnt;
    logic [KW-1:0]          digIdx;
    logic [NDIG-1:0][DW-1:0] shadow;
    logic [NDIG-1:0][DW-1:0] nextShadow;
    logic [NDIG-1:0][DW-1:0] digitsQ;
    logic                   busyQ, doneQ, errQ, ovfQ;
    logic [DW+1:0]          trial, diff;
    logic                   geq, radixOk, lastDig;

    function automatic logic [6:0] hexSeg(input logic [DW-1:0] d);
        case (32'(d))
            0:  return 7'h40;
            1:  return 7'h79;
            2:  return 7'h24;
            3:  return 7'h30;
            4:  return 7'h19;
            5:  return 7'h12;
            6:  return 7'h02;
            7:  return 7'h78;
            8:  return 7'h00;
            9:  return 7'h10;
            10: return 7'h08;
            11: return 7'h03;
            12: return 7'h46;
            13: return 7'h21;
            14: return 7'h06;
            15: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    // Borrow out of the trial subtraction decides the quotient bit.
    always_comb begin
        trial      = {rem, dvd[WIDTH-1]};
        diff       = trial - {1'b0, radixQ};
        geq        = ~diff[DW+1];
        radixOk    = (bus.radix >= (DW+1)'(2)) && (bus.radix <= RADIX_MAX);
        lastDig    = (digIdx == KW'(NDIG - 1));
        nextShadow = shadow;
        nextShadow[digIdx] = rem[DW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dvd     <= '0;
            rem     <= '0;
            radixQ  <= '0;
            bitCnt  <= '0;
            digIdx  <= '0;
            shadow  <= '0;
            digitsQ <= '0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
            errQ    <= 1'b0;
            ovfQ    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    doneQ <= 1'b0;
                    if (bus.start) begin
                        dvd    <= bus.value;
                        radixQ <= bus.radix;
                        rem    <= '0;
                        bitCnt <= '0;
                        digIdx <= '0;
                        if (radixOk) begin
                            busyQ <= 1'b1;
                            state <= DIV;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DIV: begin
                    dvd <= {dvd[WIDTH-2:0], geq};
                    rem <= geq ? diff[DW:0] : trial[DW:0];
                    if (bitCnt == CW'(WIDTH - 1)) begin
                        bitCnt <= '0;
                        state  <= NEXT;
                    end else begin
                        bitCnt <= bitCnt + CW'(1);
                    end
                end
                NEXT: begin
                    shadow <= nextShadow;
                    rem    <= '0;
                    digIdx <= digIdx + KW'(1);
                    if (lastDig) begin
                        digitsQ <= nextShadow;
                        ovfQ    <= |dvd;
                        errQ    <= 1'b0;
                        doneQ   <= 1'b1;
                        busyQ   <= 1'b0;
                        state   <= DONE;
                    end else begin
                        state <= DIV;
                    end
                end
                DONE: begin
                    // Entered with done low only on the illegal-radix path:
                    // spend one cycle there, then raise done with err.
                    if (doneQ) begin
                        doneQ <= 1'b0;
                        state <= IDLE;
                    end else begin
                        doneQ   <= 1'b1;
                        errQ    <= 1'b1;
                        ovfQ    <= 1'b0;
                        digitsQ <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [NDIG-1:0][6:0] segQ;
    logic                 anyNz;

    always_comb begin
        anyNz = 1'b0;
        segQ  = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            anyNz = anyNz | (|digitsQ[k]);
            if (LZB != 0 && k != 0 && !anyNz) segQ[k] = 7'h7F;
            else                              segQ[k] = hexSeg(digitsQ[k]);
        end
    end

    assign bus.busy     = busyQ;
    assign bus.done     = doneQ;
    assign bus.err      = errQ;
    assign bus.overflow = ovfQ;
    assign bus.digits   = digitsQ;
    assign bus.seg      = segQ;
endmodule

// File: tb/tb_radix_digit_extractor.sv
// Directed bench for radix_digit_extractor: two instances (LZB=0 and LZB=1) share stimulus.
module tb_radix_digit_extractor;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] value;
    logic [4:0]  radix;
    int          total = 0;
    int          bad   = 0;

    radix_digit_extractor_if #(.WIDTH(32), .NDIG(6), .DW(4)) busA ();
    radix_digit_extractor_if #(.WIDTH(32), .NDIG(6), .DW(4)) busB ();

    assign busA.start = start;
    assign busA.value = value;
    assign busA.radix = radix;
    assign busB.start = start;
    assign busB.value = value;
    assign busB.radix = radix;

    radix_digit_extractor #(.WIDTH(32), .NDIG(6), .DW(4), .LZB(0)) dutA (
        .clk(clk), .rst(rst), .bus(busA.slave));
    radix_digit_extractor #(.WIDTH(32), .NDIG(6), .DW(4), .LZB(1)) dutB (
        .clk(clk), .rst(rst), .bus(busB.slave));

    always #5 clk = ~clk;

    // Start high at one negedge, low at the next; returns half a cycle after the accepting edge.
    task automatic launch(input logic [31:0] v, input logic [4:0] r);
        @(negedge clk);
        value = v;
        radix = r;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen; -1 on timeout.
    task automatic waitDone(input int limit, output int cyc, output logic busySeen);
        cyc      = 0;
        busySeen = busA.busy;
        while (!busA.done && cyc < limit) begin
            @(negedge clk);
            cyc++;
            busySeen = busySeen | busA.busy;
        end
        if (!busA.done) cyc = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; value = '0; radix = '0;
        repeat (2) @(negedge clk);
        total++; if ({busA.busy, busA.done, busA.err, busA.overflow} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {busA.busy, busA.done, busA.err, busA.overflow}); end
        total++; if (busA.digits !== 24'h0) begin
            bad++; $display("FAIL reset_digits got=%h want=000000", busA.digits); end
        total++; if (busA.seg !== {6{7'h40}}) begin
            bad++; $display("FAIL reset_seg got=%h want=%h", busA.seg, {6{7'h40}}); end
        total++; if (busB.seg !== {{5{7'h7F}}, 7'h40}) begin
            bad++; $display("FAIL reset_seg_lzb got=%h want=%h", busB.seg, {{5{7'h7F}}, 7'h40}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_decimal;
        int cyc; logic bs;
        launch(32'd123456, 5'd10);
        waitDone(400, cyc, bs);
        total++; if (cyc !== 198) begin bad++; $display("FAIL dec_latency got=%0d want=198", cyc); end
        total++; if (busA.digits !== 24'h123456) begin
            bad++; $display("FAIL dec_digits got=%h want=123456", busA.digits); end
        total++; if ({busA.err, busA.overflow} !== 2'b00) begin
            bad++; $display("FAIL dec_flags got=%b want=00", {busA.err, busA.overflow}); end
        total++; if (bs !== 1'b1) begin bad++; $display("FAIL dec_busy got=%b want=1", bs); end
        @(negedge clk);
        total++; if (busA.done !== 1'b0) begin bad++; $display("FAIL dec_done_pulse got=%b want=0", busA.done); end
        total++; if (busA.digits !== 24'h123456) begin
            bad++; $display("FAIL dec_hold got=%h want=123456", busA.digits); end
    endtask

    task automatic test_hex;
        int cyc; logic bs;
        launch(32'h00ABCDEF, 5'd16);
        waitDone(400, cyc, bs);
        total++; if (busA.digits !== 24'hABCDEF) begin
            bad++; $display("FAIL hex_digits got=%h want=abcdef", busA.digits); end
        total++; if (busA.seg[6:0] !== 7'b0001110) begin
            bad++; $display("FAIL hex_seg0 got=%b want=0001110", busA.seg[6:0]); end
        total++; if (busA.seg !== {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}) begin
            bad++; $display("FAIL hex_seg got=%h want=%h", busA.seg, {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}); end
    endtask

    task automatic test_overflow;
        int cyc; logic bs;
        launch(32'd1234567, 5'd10);
        waitDone(400, cyc, bs);
        total++; if (busA.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", busA.overflow); end
        total++; if (busA.digits !== 24'h234567) begin
            bad++; $display("FAIL ovf_digits got=%h want=234567", busA.digits); end
    endtask

    task automatic test_err;
        int cyc; logic bs;
        logic [4:0] rads [2] = '{5'd1, 5'd17};
        foreach (rads[i]) begin
            launch(32'd987, rads[i]);
            waitDone(20, cyc, bs);
            total++; if (cyc !== 1) begin bad++; $display("FAIL err_latency r=%0d got=%0d want=1", rads[i], cyc); end
            total++; if ({busA.err, busA.overflow} !== 2'b10) begin
                bad++; $display("FAIL err_flags r=%0d got=%b want=10", rads[i], {busA.err, busA.overflow}); end
            total++; if (busA.digits !== 24'h0) begin
                bad++; $display("FAIL err_digits r=%0d got=%h want=000000", rads[i], busA.digits); end
            total++; if (bs !== 1'b0) begin bad++; $display("FAIL err_busy r=%0d got=%b want=0", rads[i], bs); end
        end
    endtask

    task automatic test_lzb;
        int cyc; logic bs;
        launch(32'd42, 5'd10);
        waitDone(400, cyc, bs);
        total++; if (busB.digits !== 24'h000042) begin
            bad++; $display("FAIL lzb_digits got=%h want=000042", busB.digits); end
        total++; if (busB.err !== 1'b0) begin bad++; $display("FAIL lzb_err got=%b want=0", busB.err); end
        total++; if (busB.seg !== {{4{7'h7F}}, 7'h19, 7'h24}) begin
            bad++; $display("FAIL lzb_seg42 got=%h want=%h", busB.seg, {{4{7'h7F}}, 7'h19, 7'h24}); end
        total++; if (busA.seg !== {{4{7'h40}}, 7'h19, 7'h24}) begin
            bad++; $display("FAIL nolzb_seg42 got=%h want=%h", busA.seg, {{4{7'h40}}, 7'h19, 7'h24}); end
        launch(32'd0, 5'd10);
        waitDone(400, cyc, bs);
        total++; if (busB.seg !== {{5{7'h7F}}, 7'h40}) begin
            bad++; $display("FAIL lzb_seg0 got=%h want=%h", busB.seg, {{5{7'h7F}}, 7'h40}); end
    endtask

    task automatic test_abort;
        int cyc; logic bs; logic sawDone;
        launch(32'd123456, 5'd10);
        cyc = 0;
        while (!busA.done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 50) begin start = 1'b1; value = 32'd999; end
            if (cyc == 51) start = 1'b0;
        end
        total++; if (cyc !== 198) begin bad++; $display("FAIL busy_start_latency got=%0d want=198", cyc); end
        total++; if (busA.digits !== 24'h123456) begin
            bad++; $display("FAIL busy_start_digits got=%h want=123456", busA.digits); end
        launch(32'd654321, 5'd10);
        sawDone = 1'b0;
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            sawDone = sawDone | busA.done;
        end
        rst = 1'b1;
        #1;
        total++; if ({busA.busy, busA.done} !== 2'b00) begin
            bad++; $display("FAIL abort_flags got=%b want=00", {busA.busy, busA.done}); end
        total++; if (busA.digits !== 24'h0) begin
            bad++; $display("FAIL abort_digits got=%h want=000000", busA.digits); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            sawDone = sawDone | busA.done;
        end
        total++; if (sawDone !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b want=0", sawDone); end
        launch(32'd777, 5'd10);
        waitDone(400, cyc, bs);
        total++; if (cyc !== 198) begin bad++; $display("FAIL post_reset_latency got=%0d want=198", cyc); end
        total++; if (busA.digits !== 24'h000777) begin
            bad++; $display("FAIL post_reset_digits got=%h want=000777", busA.digits); end
    endtask

    // Start held through done: the DONE cycle ignores it, the following IDLE accepts it.
    task automatic test_back_to_back;
        int cyc; logic bs;
        @(negedge clk);
        value = 32'd99; radix = 5'd10; start = 1'b1;
        @(negedge clk);
        waitDone(400, cyc, bs);
        total++; if (cyc !== 198) begin bad++; $display("FAIL b2b_first got=%0d want=198", cyc); end
        @(negedge clk);
        waitDone(400, cyc, bs);
        start = 1'b0;
        total++; if (cyc !== 199) begin bad++; $display("FAIL b2b_second got=%0d want=199", cyc); end
        total++; if (busA.digits !== 24'h000099) begin
            bad++; $display("FAIL b2b_digits got=%h want=000099", busA.digits); end
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_hex();
        test_overflow();
        test_err();
        test_lzb();
        test_abort();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
